// File: rtl/sin_arbiter_if.sv
// Handshake bundle between the sin arbiter, its four clients and the shared
// sin core. The arbiter takes the slave view; the environment takes the
// master view.
interface sin_arbiter_if;
  logic [3:0]  req_valid;
  logic [63:0] req_x;
  logic [3:0]  req_ack;
  logic [3:0]  resp_valid;
  logic [15:0] resp_result;
  logic        resp_err;
  logic        core_start;
  logic [15:0] core_x;
  logic [15:0] core_result;
  logic        core_done;

  modport slave (
    input  req_valid, req_x, core_result, core_done,
    output req_ack, resp_valid, resp_result, resp_err, core_start, core_x
  );

  modport master (
    output req_valid, req_x, core_result, core_done,
    input  req_ack, resp_valid, resp_result, resp_err, core_start, core_x
  );
endinterface

// File: rtl/sin_arbiter.sv
// Round-robin arbiter sharing one sin core among four clients, one job in
// flight at a time, with a per-job timeout that returns an error response.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | sample requests, pick client round-robin, latch operand
// ISSUE | core_start and req_ack pulse for the granted client
// WAIT  | wait for core_done, abort once the timer reaches TIMEOUT-1
// RESP  | resp_valid pulse for the granted client, advance rr pointer
module sin_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst_n,
  sin_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] rr_ptr;
  logic [1:0] grant;
  logic [7:0] timer;
  logic [1:0] pick;

  // First requesting client at or after ptr, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
    logic [1:0] sel;
    logic [1:0] idx;
    sel = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) sel = idx;
    end
    return sel;
  endfunction

  // Round-robin candidate, only consumed while in IDLE.
  always_comb pick = rr_pick(rr_ptr, bus.req_valid);

  // Job sequencing FSM; every output is registered so pulses line up with states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rr_ptr          <= 2'd0;
      grant           <= 2'd0;
      timer           <= 8'd0;
      bus.core_x      <= 16'h0000;
      bus.core_start  <= 1'b0;
      bus.req_ack     <= 4'b0000;
      bus.resp_valid  <= 4'b0000;
      bus.resp_result <= 16'h0000;
      bus.resp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.resp_valid <= 4'b0000;
          if (|bus.req_valid) begin
            grant          <= pick;
            bus.core_x     <= bus.req_x[{pick, 4'b0000} +: 16];
            bus.core_start <= 1'b1;
            bus.req_ack    <= 4'b0001 << pick;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          bus.core_start <= 1'b0;
          bus.req_ack    <= 4'b0000;
          timer          <= 8'd0;
          state          <= WAIT;
        end
        WAIT: begin
          // core_done takes priority over a timeout in the same cycle
          if (bus.core_done) begin
            bus.resp_result <= bus.core_result;
            bus.resp_err    <= 1'b0;
            bus.resp_valid  <= 4'b0001 << grant;
            state           <= RESP;
          end else if (timer == TIMER_LAST) begin
            bus.resp_result <= 16'h0000;
            bus.resp_err    <= 1'b1;
            bus.resp_valid  <= 4'b0001 << grant;
            state           <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          bus.resp_valid <= 4'b0000;
          rr_ptr         <= grant + 2'd1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
